// File: rtl/secant_pkg.sv
// Shared state encoding, width helpers and magnitude function for the secant tuner.
package secant_pkg;

    localparam int WIDTH_DEF    = 10;
    localparam int TOL_DEF      = 30;
    localparam int MAX_ITER_DEF = 16;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_SET_A  = 4'd1,
        ST_WAIT_A = 4'd2,
        ST_SET_B  = 4'd3,
        ST_WAIT_B = 4'd4,
        ST_CALC   = 4'd5,
        ST_DIV    = 4'd6,
        ST_SET_C  = 4'd7,
        ST_WAIT_C = 4'd8,
        ST_CHECK  = 4'd9,
        ST_FIN    = 4'd10
    } state_t;

    // Errors carry one extra bit so f - desired never wraps.
    function automatic int err_w(input int w);
        return w + 1;
    endfunction

    // Wide enough to hold e * (b - a) without overflow.
    function automatic int step_w(input int w);
        return 2 * w + 2;
    endfunction

    function automatic int abs_val(input int x);
        return (x < 0) ? -x : x;
    endfunction

endpackage

// File: rtl/seq_div_signed.sv
// Sequential signed restoring divider; one quotient bit per cycle, result truncated toward zero.
module seq_div_signed #(
    parameter int NW = 22,
    parameter int DW = 11
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic signed [NW-1:0] num,
    input  logic signed [DW-1:0] den,
    output logic                 done,
    output logic signed [NW-1:0] quot
);

    localparam int CW = $clog2(NW + 1);

    logic                 busy_q, busy_d;
    logic                 neg_q, neg_d;
    logic                 done_q, done_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [DW-1:0]        rem_q, rem_d;
    logic [DW-1:0]        dabs_q, dabs_d;
    logic [NW-1:0]        quo_q, quo_d;
    logic signed [NW-1:0] quot_q, quot_d;

    logic [DW:0]          trial;
    logic [DW:0]          diff;
    logic [NW-1:0]        quo_next;
    logic [DW-1:0]        rem_next;

    always_comb begin
        busy_d   = busy_q;
        neg_d    = neg_q;
        done_d   = 1'b0;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        dabs_d   = dabs_q;
        quo_d    = quo_q;
        quot_d   = quot_q;

        trial    = {rem_q, quo_q[NW-1]};
        diff     = trial - {1'b0, dabs_q};
        quo_next = {quo_q[NW-2:0], 1'b0};
        rem_next = trial[DW-1:0];
        if (trial >= {1'b0, dabs_q}) begin
            rem_next    = diff[DW-1:0];
            quo_next[0] = 1'b1;
        end

        if (start) begin
            // Divide magnitudes, then restore the sign on the way out.
            quo_d  = num[NW-1] ? NW'(-num) : NW'(num);
            dabs_d = den[DW-1] ? DW'(-den) : DW'(den);
            neg_d  = num[NW-1] ^ den[DW-1];
            rem_d  = '0;
            cnt_d  = CW'(NW);
            busy_d = 1'b1;
        end else if (busy_q) begin
            quo_d = quo_next;
            rem_d = rem_next;
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
                quot_d = neg_q ? -$signed(quo_next) : $signed(quo_next);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            neg_q  <= 1'b0;
            done_q <= 1'b0;
            cnt_q  <= '0;
            rem_q  <= '0;
            dabs_q <= '0;
            quo_q  <= '0;
            quot_q <= '0;
        end else begin
            busy_q <= busy_d;
            neg_q  <= neg_d;
            done_q <= done_d;
            cnt_q  <= cnt_d;
            rem_q  <= rem_d;
            dabs_q <= dabs_d;
            quo_q  <= quo_d;
            quot_q <= quot_d;
        end
    end

    assign done = done_q;
    assign quot = quot_q;

endmodule

// File: rtl/secant_tuner.sv
// Closed-loop secant tuner: steps i_ref until the measured Q lands within TOL of the target,
// falling back to the best point seen when iterations run out or the secant step stalls.
module secant_tuner
    import secant_pkg::*;
#(
    parameter int WIDTH    = WIDTH_DEF,
    parameter int TOL      = TOL_DEF,
    parameter int MAX_ITER = MAX_ITER_DEF
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [WIDTH-1:0]             desired_q,
    input  logic [WIDTH-1:0]             i_ref_lo,
    input  logic [WIDTH-1:0]             i_ref_hi,
    input  logic                         meas_valid,
    input  logic [WIDTH-1:0]             measured_q,
    output logic [WIDTH-1:0]             i_ref,
    output logic                         meas_req,
    output logic                         busy,
    output logic                         done,
    output logic                         converged,
    output logic                         timeout,
    output logic [$clog2(MAX_ITER+1)-1:0] iter_count
);

    localparam int EW = err_w(WIDTH);
    localparam int SW = step_w(WIDTH);
    localparam int IW = $clog2(MAX_ITER + 1);

    state_t state_q, state_d;

    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
    logic [WIDTH-1:0] f_a_q, f_a_d, f_b_q, f_b_d, f_c_q, f_c_d;
    logic [WIDTH-1:0] target_q, target_d;
    logic [WIDTH-1:0] i_ref_q, i_ref_d;
    logic [WIDTH-1:0] best_x_q, best_x_d;
    logic [EW-1:0]    best_e_q, best_e_d;
    logic signed [SW-1:0] step_q, step_d;
    logic [IW-1:0]    iter_q, iter_d;
    logic             meas_req_q, meas_req_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             converged_q, converged_d;
    logic             timeout_q, timeout_d;

    logic                 div_start;
    logic                 div_done;
    logic signed [SW-1:0] div_quot;

    logic signed [EW-1:0] e_meas, e_b, e_c, den, diff_ba;
    logic signed [SW-1:0] e_b_w, diff_w, num, c_wide;
    logic [WIDTH-1:0]     c_clamped;
    logic [IW-1:0]        iter_inc;
    int                   abs_meas, abs_c;
    logic                 better;

    // Secant arithmetic shared by several states.
    always_comb begin
        e_meas  = $signed({1'b0, measured_q}) - $signed({1'b0, target_q});
        e_b     = $signed({1'b0, f_b_q}) - $signed({1'b0, target_q});
        e_c     = $signed({1'b0, f_c_q}) - $signed({1'b0, target_q});
        den     = $signed({1'b0, f_b_q}) - $signed({1'b0, f_a_q});
        diff_ba = $signed({1'b0, b_q}) - $signed({1'b0, a_q});
        e_b_w   = {{(SW-EW){e_b[EW-1]}}, e_b};
        diff_w  = {{(SW-EW){diff_ba[EW-1]}}, diff_ba};
        num     = e_b_w * diff_w;
        c_wide  = $signed({{(SW-WIDTH){1'b0}}, b_q}) - step_q;

        if (c_wide[SW-1]) begin
            c_clamped = '0;
        end else if (|c_wide[SW-2:WIDTH]) begin
            c_clamped = '1;
        end else begin
            c_clamped = c_wide[WIDTH-1:0];
        end

        abs_meas = abs_val(int'(e_meas));
        abs_c    = abs_val(int'(e_c));
        better   = abs_meas < int'(best_e_q);
        iter_inc = iter_q + IW'(1);
    end

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        c_d         = c_q;
        f_a_d       = f_a_q;
        f_b_d       = f_b_q;
        f_c_d       = f_c_q;
        target_d    = target_q;
        i_ref_d     = i_ref_q;
        best_x_d    = best_x_q;
        best_e_d    = best_e_q;
        step_d      = step_q;
        iter_d      = iter_q;
        busy_d      = busy_q;
        converged_d = converged_q;
        timeout_d   = timeout_q;
        meas_req_d  = 1'b0;
        done_d      = 1'b0;
        div_start   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d         = i_ref_lo;
                    b_d         = i_ref_hi;
                    target_d    = desired_q;
                    converged_d = 1'b0;
                    timeout_d   = 1'b0;
                    iter_d      = '0;
                    busy_d      = 1'b1;
                    best_e_d    = '1;
                    best_x_d    = i_ref_lo;
                    state_d     = ST_SET_A;
                end
            end
            ST_SET_A: begin
                i_ref_d    = a_q;
                meas_req_d = 1'b1;
                state_d    = ST_WAIT_A;
            end
            ST_WAIT_A: begin
                if (meas_valid) begin
                    f_a_d = measured_q;
                    if (better) begin
                        best_e_d = EW'(abs_meas);
                        best_x_d = i_ref_q;
                    end
                    if (abs_meas < TOL) begin
                        converged_d = 1'b1;
                        done_d      = 1'b1;
                        state_d     = ST_FIN;
                    end else begin
                        state_d = ST_SET_B;
                    end
                end
            end
            ST_SET_B: begin
                i_ref_d    = b_q;
                meas_req_d = 1'b1;
                state_d    = ST_WAIT_B;
            end
            ST_WAIT_B: begin
                if (meas_valid) begin
                    f_b_d = measured_q;
                    if (better) begin
                        best_e_d = EW'(abs_meas);
                        best_x_d = i_ref_q;
                    end
                    if (abs_meas < TOL) begin
                        converged_d = 1'b1;
                        done_d      = 1'b1;
                        state_d     = ST_FIN;
                    end else begin
                        state_d = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                // A flat secant has no slope; step by the raw error instead of dividing by zero.
                if (den == '0) begin
                    step_d  = e_b_w;
                    state_d = ST_SET_C;
                end else begin
                    div_start = 1'b1;
                    state_d   = ST_DIV;
                end
            end
            ST_DIV: begin
                if (div_done) begin
                    step_d  = div_quot;
                    state_d = ST_SET_C;
                end
            end
            ST_SET_C: begin
                if (c_clamped == b_q) begin
                    timeout_d = 1'b1;
                    done_d    = 1'b1;
                    state_d   = ST_FIN;
                end else begin
                    c_d        = c_clamped;
                    i_ref_d    = c_clamped;
                    meas_req_d = 1'b1;
                    state_d    = ST_WAIT_C;
                end
            end
            ST_WAIT_C: begin
                if (meas_valid) begin
                    f_c_d = measured_q;
                    if (better) begin
                        best_e_d = EW'(abs_meas);
                        best_x_d = i_ref_q;
                    end
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                iter_d = iter_inc;
                if (abs_c < TOL) begin
                    converged_d = 1'b1;
                    done_d      = 1'b1;
                    state_d     = ST_FIN;
                end else if (iter_inc == IW'(MAX_ITER)) begin
                    timeout_d = 1'b1;
                    done_d    = 1'b1;
                    state_d   = ST_FIN;
                end else begin
                    a_d     = b_q;
                    f_a_d   = f_b_q;
                    b_d     = c_q;
                    f_b_d   = f_c_q;
                    state_d = ST_CALC;
                end
            end
            ST_FIN: begin
                if (timeout_q) begin
                    i_ref_d = best_x_q;
                end
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            c_q         <= '0;
            f_a_q       <= '0;
            f_b_q       <= '0;
            f_c_q       <= '0;
            target_q    <= '0;
            i_ref_q     <= '0;
            best_x_q    <= '0;
            best_e_q    <= '0;
            step_q      <= '0;
            iter_q      <= '0;
            meas_req_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            converged_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            c_q         <= c_d;
            f_a_q       <= f_a_d;
            f_b_q       <= f_b_d;
            f_c_q       <= f_c_d;
            target_q    <= target_d;
            i_ref_q     <= i_ref_d;
            best_x_q    <= best_x_d;
            best_e_q    <= best_e_d;
            step_q      <= step_d;
            iter_q      <= iter_d;
            meas_req_q  <= meas_req_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            converged_q <= converged_d;
            timeout_q   <= timeout_d;
        end
    end

    seq_div_signed #(
        .NW(SW),
        .DW(EW)
    ) u_div (
        .clk   (clk),
        .rst_n (rst_n),
        .start (div_start),
        .num   (num),
        .den   (den),
        .done  (div_done),
        .quot  (div_quot)
    );

    assign i_ref      = i_ref_q;
    assign meas_req   = meas_req_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign converged  = converged_q;
    assign timeout    = timeout_q;
    assign iter_count = iter_q;

endmodule
